// File: rtl/mtsp_gscs_counter_if.sv
// Control and observation bundle for the GSC scratch-coordinate counters.
interface mtsp_gscs_counter_if #(
    parameter int CW = 8
);
    logic            EN;
    logic [3:0]      GSCs_RST;
    logic [3:0]      GSCs_INC;
    logic            CFG_WE;
    logic [2:0]      CFG_SEL;
    logic [CW-1:0]   CFG_DATA;
    logic [4*CW-1:0] GSC_COORD;
    logic [3:0]      GSC_WRAP;
    logic            GSC_DONE;

    // Pipeline/decoder side: drives masks and configuration, observes coordinate
    modport master (
        output EN, GSCs_RST, GSCs_INC, CFG_WE, CFG_SEL, CFG_DATA,
        input  GSC_COORD, GSC_WRAP, GSC_DONE
    );

    // Counter block side
    modport slave (
        input  EN, GSCs_RST, GSCs_INC, CFG_WE, CFG_SEL, CFG_DATA,
        output GSC_COORD, GSC_WRAP, GSC_DONE
    );
endinterface

// File: rtl/mtsp_gscs_counter.sv
// Four scratch-coordinate counters (X,Y,Z,W) with per-component wrap limits
// and an optional X->Y->Z->W carry chain. Index 3 is X, index 0 is W, matching
// the mask bit order, so chain bit c gates the carry into component c.
module mtsp_gscs_counter #(
    parameter int         CW            = 8,
    parameter logic [2:0] CHAIN_DEFAULT = 3'b000
) (
    input logic                 CLK,
    input logic                 nRST,
    mtsp_gscs_counter_if.slave  bus
);

    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [3:0][CW-1:0] lim_q, lim_d;
    logic [2:0]         chain_q, chain_d;
    logic [3:0]         wrap_q, wrap_d;
    logic               done_q, done_d;

    logic [3:0][CW-1:0] cnt_n;
    logic [3:0]         wrap_c;
    logic [3:0]         chain_ext;
    logic [15:0]        cfg_ext;
    logic               carry;
    logic               inc_v;
    logic               at_lim;

    // Configuration writes: independent of EN, visible from the next edge
    always_comb begin
        lim_d   = lim_q;
        chain_d = chain_q;
        cfg_ext = 16'(bus.CFG_DATA);
        if (bus.CFG_WE) begin
            if (!bus.CFG_SEL[2])
                lim_d[2'd3 - bus.CFG_SEL[1:0]] = bus.CFG_DATA;
            else if (bus.CFG_SEL == 3'd4)
                chain_d = cfg_ext[2:0];
        end
    end

    // Counter arithmetic with carry ripple X->Y->Z->W; reset beats inc and kills carry
    always_comb begin
        cnt_n     = cnt_q;
        wrap_c    = '0;
        chain_ext = {1'b0, chain_q};
        carry     = 1'b0;
        inc_v     = 1'b0;
        at_lim    = 1'b0;
        for (int c = 3; c >= 0; c--) begin
            inc_v     = bus.GSCs_INC[c] | (chain_ext[c] & carry);
            at_lim    = (cnt_q[c] >= lim_q[c]);
            wrap_c[c] = ~bus.GSCs_RST[c] & inc_v & at_lim;
            if (bus.GSCs_RST[c])
                cnt_n[c] = '0;
            else if (inc_v)
                cnt_n[c] = at_lim ? '0 : cnt_q[c] + CW'(1);
            carry = wrap_c[c];
        end
    end

    // Next-state selection: EN=0 freezes counters and drops the wrap pulse
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = '0;
        done_d = done_q;
        if (bus.EN) begin
            cnt_d  = cnt_n;
            wrap_d = wrap_c;
            if (bus.GSCs_RST[0])
                done_d = 1'b0;
            else if (wrap_c[0])
                done_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q   <= '0;
            lim_q   <= '1;
            chain_q <= CHAIN_DEFAULT;
            wrap_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            chain_q <= chain_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign bus.GSC_COORD = cnt_q;
    assign bus.GSC_WRAP  = wrap_q;
    assign bus.GSC_DONE  = done_q;

endmodule

// File: tb/tb_mtsp_gscs_counter.sv
// Directed bench for mtsp_gscs_counter (CW=8, chain off at reset).
module tb_mtsp_gscs_counter;

    logic CLK;
    logic nRST;
    int   total;
    int   bad;

    mtsp_gscs_counter_if #(.CW(8)) bus ();

    mtsp_gscs_counter #(.CW(8), .CHAIN_DEFAULT(3'b000)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] co(int x, int y, int z, int w);
        return {8'(x), 8'(y), 8'(z), 8'(w)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given masks; outputs are sampled 1 time unit after the edge
    task automatic step(input logic en, input logic [3:0] rst, input logic [3:0] inc);
        bus.EN       = en;
        bus.GSCs_RST = rst;
        bus.GSCs_INC = inc;
        @(posedge CLK);
        #1;
        bus.EN       = 1'b0;
        bus.GSCs_RST = 4'h0;
        bus.GSCs_INC = 4'h0;
    endtask

    task automatic cfg(input logic [2:0] sel, input logic [7:0] data);
        bus.CFG_WE   = 1'b1;
        bus.CFG_SEL  = sel;
        bus.CFG_DATA = data;
        step(1'b0, 4'h0, 4'h0);
        bus.CFG_WE   = 1'b0;
    endtask

    int ex_x [12] = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
    int ex_y [12] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    int ex_w [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    logic [3:0] ex_wr [12] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'hE,
                              4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'hF};

    initial begin
        total = 0;
        bad   = 0;
        nRST         = 1'b0;
        bus.EN       = 1'b0;
        bus.GSCs_RST = 4'h0;
        bus.GSCs_INC = 4'h0;
        bus.CFG_WE   = 1'b0;
        bus.CFG_SEL  = 3'd0;
        bus.CFG_DATA = 8'h00;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Reset mid-count
        for (int i = 0; i < 5; i++) step(1'b1, 4'h0, 4'h8);
        chk("pre_reset_x5", bus.GSC_COORD, co(5, 0, 0, 0));
        nRST = 1'b0;
        step(1'b1, 4'h0, 4'h8);
        nRST = 1'b1;
        chk("rst_coord", bus.GSC_COORD, 32'h0);
        chk("rst_wrap", bus.GSC_WRAP, 4'h0);
        chk("rst_done", bus.GSC_DONE, 1'b0);
        step(1'b1, 4'h0, 4'h8);
        chk("post_rst_inc", bus.GSC_COORD, co(1, 0, 0, 0));
        nRST = 1'b0;
        step(1'b0, 4'h0, 4'h0);
        nRST = 1'b1;

        // Wrap and chain walk
        cfg(3'd0, 8'd2);
        cfg(3'd1, 8'd1);
        cfg(3'd2, 8'd0);
        cfg(3'd3, 8'd1);
        cfg(3'd4, 8'h07);
        chk("cfg_no_count", bus.GSC_COORD, 32'h0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'h0, 4'h8);
            chk($sformatf("walk_coord_%0d", i + 1), bus.GSC_COORD, co(ex_x[i], ex_y[i], 0, ex_w[i]));
            chk($sformatf("walk_wrap_%0d", i + 1), bus.GSC_WRAP, ex_wr[i]);
            chk($sformatf("walk_done_%0d", i + 1), bus.GSC_DONE, (i == 11) ? 1'b1 : 1'b0);
        end

        // RST vs INC on W, done cleared
        step(1'b1, 4'h0, 4'h1);
        chk("w_to_1", bus.GSC_COORD, co(0, 0, 0, 1));
        chk("done_held", bus.GSC_DONE, 1'b1);
        step(1'b1, 4'h1, 4'h1);
        chk("rstw_coord", bus.GSC_COORD, 32'h0);
        chk("rstw_wrap", bus.GSC_WRAP, 4'h0);
        chk("rstw_done", bus.GSC_DONE, 1'b0);

        // Own INC and carry together increment Y once
        step(1'b1, 4'h0, 4'h8);
        step(1'b1, 4'h0, 4'h8);
        chk("x_at_lim", bus.GSC_COORD, co(2, 0, 0, 0));
        step(1'b1, 4'h0, 4'hC);
        chk("sim_coord", bus.GSC_COORD, co(0, 1, 0, 0));
        chk("sim_wrap", bus.GSC_WRAP, 4'h8);
        step(1'b1, 4'h4, 4'h0);
        step(1'b1, 4'h0, 4'h8);
        step(1'b1, 4'h0, 4'h8);
        chk("x_at_lim2", bus.GSC_COORD, co(2, 0, 0, 0));
        // Reset X at its limit: no wrap, no carry into Y
        step(1'b1, 4'h8, 4'h8);
        chk("rstx_coord", bus.GSC_COORD, 32'h0);
        chk("rstx_wrap", bus.GSC_WRAP, 4'h0);

        // Stall with all masks set
        step(1'b1, 4'h0, 4'hF);
        chk("all_inc_coord", bus.GSC_COORD, co(1, 1, 0, 1));
        chk("all_inc_wrap", bus.GSC_WRAP, 4'h2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0, 4'hF);
            chk($sformatf("stall_coord_%0d", i), bus.GSC_COORD, co(1, 1, 0, 1));
            chk($sformatf("stall_wrap_%0d", i), bus.GSC_WRAP, 4'h0);
        end
        step(1'b1, 4'h0, 4'hF);
        chk("unstall_coord", bus.GSC_COORD, co(2, 0, 0, 0));
        chk("unstall_wrap", bus.GSC_WRAP, 4'h7);
        chk("unstall_done", bus.GSC_DONE, 1'b1);

        // Limit reprogram from default limits
        nRST = 1'b0;
        step(1'b0, 4'h0, 4'h0);
        nRST = 1'b1;
        for (int i = 0; i < 200; i++) step(1'b1, 4'h0, 4'h8);
        chk("x200", bus.GSC_COORD, co(200, 0, 0, 0));
        bus.CFG_WE   = 1'b1;
        bus.CFG_SEL  = 3'd0;
        bus.CFG_DATA = 8'd10;
        step(1'b1, 4'h0, 4'h8);
        bus.CFG_WE   = 1'b0;
        chk("x201_old_lim", bus.GSC_COORD, co(201, 0, 0, 0));
        chk("x201_wrap", bus.GSC_WRAP, 4'h0);
        step(1'b1, 4'h0, 4'h8);
        chk("above_lim_coord", bus.GSC_COORD, 32'h0);
        chk("above_lim_wrap", bus.GSC_WRAP, 4'h8);

        // Ignored select must not touch limits or chain
        cfg(3'd6, 8'h07);
        cfg(3'd7, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b1, 4'h0, 4'h8);
        chk("sel6_x10", bus.GSC_COORD, co(10, 0, 0, 0));
        step(1'b1, 4'h0, 4'h8);
        chk("sel6_coord", bus.GSC_COORD, 32'h0);
        chk("sel6_wrap", bus.GSC_WRAP, 4'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
